// File: rtl/clip_ctrl_pkg.sv
// Shared types and constants for the clip record/playback controller.
package clip_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam int   CLIP_DEPTH_DEFAULT = 16384;
    localparam logic MODE_REC           = 1'b1;
    localparam logic MODE_PLAY          = 1'b0;

endpackage

// File: rtl/clip_record_controller_rise_detect.sv
// Rising-edge detector; the history bit resets high so a level already
// present when reset releases is not taken as a new press.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/clip_record_controller.sv
// Two-clip record/playback sequencer: walks a sample offset on each audio
// tick and tracks how many samples each clip holds.
//
// state  | meaning
// IDLE   | waiting for an action press
// RECORD | writing one sample per tick into the selected clip
// PLAY   | reading one sample per tick until the clip length is reached
module clip_record_controller
    import clip_ctrl_pkg::*;
#(
    parameter int CLIP_DEPTH = CLIP_DEPTH_DEFAULT,
    parameter int OFF_W      = $clog2(CLIP_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ActionSync,
    input  logic             ClipNumSync,
    input  logic             PlayOrRecordSync,
    input  logic             resetButtonSync,
    input  logic             sampleTick,
    output logic [OFF_W:0]   memAddr,
    output logic             memWe,
    output logic             playValid,
    output logic             busy,
    output logic [1:0]       stateOut
);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(CLIP_DEPTH - 1);

    state_t           state;
    logic             clip;
    logic [OFF_W-1:0] offset;
    logic [OFF_W:0]   clip_len [2];
    logic [OFF_W:0]   next_len;
    logic             action_rise;

    rise_detect u_rise (
        .clock (clock),
        .reset (reset),
        .in    (ActionSync),
        .rise  (action_rise)
    );

    // Computed one bit wider so a full clip length never overflows.
    assign next_len  = {1'b0, offset} + (OFF_W + 1)'(1);

    assign memAddr   = {clip, offset};
    assign memWe     = (state == ST_RECORD) & sampleTick & ~resetButtonSync;
    assign playValid = (state == ST_PLAY) & sampleTick & ~resetButtonSync;
    assign busy      = (state != ST_IDLE);
    assign stateOut  = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            clip        <= 1'b0;
            offset      <= '0;
            clip_len[0] <= '0;
            clip_len[1] <= '0;
        end else if (resetButtonSync) begin
            state       <= ST_IDLE;
            offset      <= '0;
            clip_len[0] <= '0;
            clip_len[1] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (action_rise) begin
                        clip   <= ClipNumSync;
                        offset <= '0;
                        if (PlayOrRecordSync == MODE_REC) begin
                            state                 <= ST_RECORD;
                            clip_len[ClipNumSync] <= '0;
                        end else if (PlayOrRecordSync == MODE_PLAY &&
                                     clip_len[ClipNumSync] != '0) begin
                            state <= ST_PLAY;
                        end
                    end
                end
                ST_RECORD: begin
                    if (sampleTick) begin
                        clip_len[clip] <= next_len;
                        if (offset == LAST_OFF) begin
                            state  <= ST_IDLE;
                            offset <= '0;
                        end else begin
                            offset <= offset + OFF_W'(1);
                        end
                    end
                    // A stop in the same cycle as a tick lands after that tick's update.
                    if (action_rise) begin
                        state  <= ST_IDLE;
                        offset <= '0;
                    end
                end
                ST_PLAY: begin
                    if (sampleTick) begin
                        if (next_len == clip_len[clip]) begin
                            state  <= ST_IDLE;
                            offset <= '0;
                        end else begin
                            offset <= offset + OFF_W'(1);
                        end
                    end
                    if (action_rise) begin
                        state  <= ST_IDLE;
                        offset <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    offset <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_record_controller.sv
// Scoreboard bench for clip_record_controller with an 8-sample clip depth.
module tb_clip_record_controller;

    localparam int DEPTH = 8;
    localparam int OW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          ActionSync, ClipNumSync, PlayOrRecordSync;
    logic          resetButtonSync, sampleTick;
    logic [OW:0]   memAddr;
    logic          memWe, playValid, busy;
    logic [1:0]    stateOut;

    int errors = 0;
    int checks = 0;

    // Expected strobe: {is_write, address}
    logic [OW+1:0] exp_q [$];

    clip_record_controller #(.CLIP_DEPTH(DEPTH), .OFF_W(OW)) dut (
        .clock            (clock),
        .reset            (reset),
        .ActionSync       (ActionSync),
        .ClipNumSync      (ClipNumSync),
        .PlayOrRecordSync (PlayOrRecordSync),
        .resetButtonSync  (resetButtonSync),
        .sampleTick       (sampleTick),
        .memAddr          (memAddr),
        .memWe            (memWe),
        .playValid        (playValid),
        .busy             (busy),
        .stateOut         (stateOut)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every strobe the DUT presents must match the next expected one.
    always @(negedge clock) begin
        if (memWe || playValid) begin
            checks++;
            if (memWe && playValid) begin
                errors++;
                $display("FAIL both_strobes: memWe=%0b playValid=%0b, required only one", memWe, playValid);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got we=%0b addr=%0d, required no strobe", memWe, memAddr);
            end else begin
                logic [OW+1:0] e;
                e = exp_q.pop_front();
                if ({memWe, memAddr} !== e) begin
                    errors++;
                    $display("FAIL strobe: got we=%0b addr=%0d, required we=%0b addr=%0d",
                             memWe, memAddr, e[OW+1], e[OW:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic act, input logic tick, input logic rb);
        ActionSync      = act;
        sampleTick      = tick;
        resetButtonSync = rb;
        @(posedge clock);
        #1;
        sampleTick      = 1'b0;
        resetButtonSync = 1'b0;
    endtask

    task automatic pulse(input logic clip_sel, input logic mode);
        ClipNumSync      = clip_sel;
        PlayOrRecordSync = mode;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Tick n times starting at offset 0; the first n_exp ticks should strobe.
    task automatic ticks(input logic clip_sel, input logic is_wr, input int n, input int n_exp);
        for (int i = 0; i < n; i++) begin
            if (i < n_exp) exp_q.push_back({is_wr, clip_sel, OW'(i)});
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic play_clip(input logic clip_sel, input int len, input string name);
        pulse(clip_sel, 1'b0);
        check({name, "_state"}, stateOut, (len == 0) ? 0 : 2);
        ticks(clip_sel, 1'b0, len + 1, len);
        check({name, "_end_state"}, stateOut, 0);
        check({name, "_end_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; ActionSync = 1'b1; ClipNumSync = 1'b0;
        PlayOrRecordSync = 1'b1; resetButtonSync = 1'b0; sampleTick = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_state", stateOut, 0);
        check("reset_busy", busy, 0);
        check("reset_addr", memAddr, 0);

        // Button held through reset release must not start anything.
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("held_button_state", stateOut, 0);
        cyc(1'b0, 1'b0, 1'b0);

        // Record clip 0: five samples, then stop with a press.
        pulse(1'b0, 1'b1);
        check("rec0_state", stateOut, 1);
        check("rec0_busy", busy, 1);
        ticks(1'b0, 1'b1, 5, 5);
        pulse(1'b0, 1'b1);
        check("rec0_stop_state", stateOut, 0);
        check("rec0_stop_addr", memAddr, 0);

        play_clip(1'b0, 5, "play0");

        // Empty clip 1: no start, but the clip select is still latched.
        pulse(1'b1, 1'b0);
        check("play1_empty_state", stateOut, 0);
        check("play1_empty_busy", busy, 0);
        check("play1_empty_addr", memAddr, 8);
        ticks(1'b1, 1'b0, 2, 0);

        // Record clip 1 past its depth; selects changed mid-record are ignored.
        pulse(1'b1, 1'b1);
        check("rec1_state", stateOut, 1);
        ClipNumSync = 1'b0; PlayOrRecordSync = 1'b0;
        ticks(1'b1, 1'b1, 8, 8);
        check("rec1_full_state", stateOut, 0);
        ticks(1'b1, 1'b1, 2, 0);
        play_clip(1'b1, 8, "play1");
        play_clip(1'b0, 5, "play0_kept");

        // Tick and stop press together: the tick still writes and counts.
        pulse(1'b0, 1'b1);
        ticks(1'b0, 1'b1, 2, 2);
        exp_q.push_back({1'b1, 1'b0, OW'(2)});
        cyc(1'b1, 1'b1, 1'b0);
        check("tick_and_stop_state", stateOut, 0);
        cyc(1'b0, 1'b0, 1'b0);
        play_clip(1'b0, 3, "play0_len3");

        // User clear mid-record, coincident with a tick.
        pulse(1'b0, 1'b1);
        ticks(1'b0, 1'b1, 2, 2);
        cyc(1'b0, 1'b1, 1'b1);
        check("clear_state", stateOut, 0);
        check("clear_addr", memAddr, 0);
        play_clip(1'b0, 0, "cleared0");
        play_clip(1'b1, 0, "cleared1");

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clip_record_controller.md
CLIP_RECORD_CONTROLLER -- requirements
Module: clip_record_controller

Interface
REQ-001 The block SHALL have parameter CLIP_DEPTH, default 16384, meaning samples per clip (power of two).
REQ-002 The block SHALL have parameter OFF_W, default $clog2(CLIP_DEPTH), meaning clip offset width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ActionSync  in  1  synchronized action button.
- ClipNumSync  in  1  clip select: 0 = clip 0, 1 = clip 1.
- PlayOrRecordSync  in  1  mode: 1 = record, 0 = play.
- resetButtonSync  in  1  synchronized user clear.
- sampleTick  in  1  one-cycle audio sample strobe.
- memAddr  out  OFF_W+1  {clip, offset}, registered.
- memWe  out  1  sample write strobe.
- playValid  out  1  sample read strobe.
- busy  out  1  high when the state is not IDLE.
- stateOut  out  2  current state encoding.

Function
REQ-005 The block SHALL detect rising edges of ActionSync with a one-cycle registered compare, giving actionRise.
REQ-006 The FSM SHALL have states IDLE=0, RECORD=1, PLAY=2; encoding 3 is unreachable and SHALL return to IDLE.
REQ-007 In IDLE, on actionRise, the block SHALL latch clip=ClipNumSync and set offset=0; the state change SHALL be visible the next cycle.
REQ-008 If PlayOrRecordSync=1, the block SHALL enter RECORD and clear clipLen[clip] to 0.
REQ-009 If PlayOrRecordSync=0 and clipLen[clip]!=0, the block SHALL enter PLAY; if clipLen[clip]==0, it SHALL remain in IDLE.
REQ-010 memWe SHALL be combinational: (state==RECORD) & sampleTick & ~resetButtonSync.
REQ-011 playValid SHALL be combinational: (state==PLAY) & sampleTick & ~resetButtonSync.
REQ-012 In RECORD, on each tick, the block SHALL set offset<=offset+1 and clipLen[clip]<=offset+1.
REQ-013 In RECORD, a tick with offset==CLIP_DEPTH-1 SHALL end recording: clipLen=CLIP_DEPTH, state<=IDLE, offset<=0, with no wrap into the other clip.
REQ-014 In PLAY, on each tick, the block SHALL set offset<=offset+1; a tick with offset+1==clipLen[clip] SHALL set state<=IDLE and offset<=0.
REQ-015 In RECORD or PLAY, actionRise SHALL return the block to IDLE next cycle; a recorded length SHALL be retained.
REQ-016 When tick and actionRise occur in the same cycle, the strobe and its length update SHALL happen first, and then the block SHALL stop.
REQ-017 ClipNumSync and PlayOrRecordSync changes outside IDLE SHALL be ignored.
REQ-018 resetButtonSync=1 SHALL, in any state, force IDLE, offset=0, and both clipLen to 0 next cycle, with priority over actionRise and sampleTick.
REQ-019 Lengths SHALL be OFF_W+1 bits (range 0..CLIP_DEPTH); offset arithmetic SHALL never overflow.

Reset
REQ-020 Reset SHALL set state=IDLE, clip=0, offset=0, memAddr=0, clipLen[0]=clipLen[1]=0, and busy=0.
REQ-021 The edge register SHALL reset to 1, so a button held through reset produces no start.
REQ-022 Reset SHALL take priority over all inputs, including resetButtonSync, and SHALL abort any recording or playback.

Structure
REQ-023 The shared package clip_ctrl_pkg SHALL hold the state enum, the CLIP_DEPTH default, and the mode constants REC=1 and PLAY=0.
REQ-024 The rising-edge detector SHALL be the sub-module rise_detect (clock, reset, in, rise).
REQ-025 Clip lengths SHALL be a two-entry register array inside the block.

Verification
REQ-026 Record clip 0 (Action pulse, Mode=1), then 5 ticks, then an Action pulse -> memWe on 5 ticks, memAddr 0..4, clipLen[0]=5, then IDLE.
REQ-027 Play clip 0 after REQ-026 -> playValid 5 times, memAddr 0..4, auto-return to IDLE after the 5th tick, busy falls.
REQ-028 Play clip 1 with length 0 -> no state change, busy stays 0, no strobes.
REQ-029 Record clip 1 with CLIP_DEPTH=8 and 10 ticks -> exactly 8 writes at addresses 8..15, clipLen[1]=8, IDLE after the 8th tick.
REQ-030 resetButtonSync asserted mid-record at the same cycle as a tick -> no memWe that cycle, IDLE next cycle, both lengths 0.
REQ-031 ActionSync held high through reset release -> block stays IDLE until the button is released and pressed again.
